axi4_lite_slave_regs: RTL and testbench

- AXI4-Lite slave register file.
- It is the DUT that the master-side driver on the AXI4-Lite interface talks to, and it consumes every master-driven channel.
- It holds NUM_REGS 32-bit registers with byte-strobed writes and decodes the address range, returning SLVERR for out-of-range accesses.
- All register contents are exported as a flat bus for downstream hardware.

---
 rtl/axi4_lite_slave_regs.sv | 206 ++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-Lite slave register file with byte-strobed writes,
//            SLVERR on out-of-range addresses, and a flat register export.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    // write response channel
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]        araddr,
    input  logic                         arvalid,
    output logic                         arready,
    // read data channel
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    // register export
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int         c_IDX_W  = $clog2(NUM_REGS);
    localparam int         c_NBYTES = DATA_WIDTH / 8;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  r_aw_held;
    logic                  r_w_held;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic                  r_aw_oor;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_NBYTES-1:0]   r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    rstate_t               r_rstate;
    rstate_t               w_rstate_nxt;
    logic                  w_arready;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic                  w_ar_oor;
    logic                  w_aw_oor;

    // Byte-offset bits are not used for decoding
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, awaddr[1:0], araddr[1:0]};

    assign awready  = !r_aw_held;
    assign wready   = !r_w_held;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign arready  = w_arready;
    assign rvalid   = (r_rstate == R_DATA);
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;

    assign w_aw_hs  = awvalid && !r_aw_held;
    assign w_w_hs   = wvalid && !r_w_held;
    assign w_ar_hs  = arvalid && w_arready;
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;

    // Anything at or above 4*NUM_REGS, including nonzero upper bits, is out of range
    assign w_aw_oor = (awaddr >> (c_IDX_W + 2)) != '0;
    assign w_ar_oor = (araddr >> (c_IDX_W + 2)) != '0;
    assign w_ar_idx = araddr[c_IDX_W+1:2];

    // Write address/data capture; both flags drop together on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[c_IDX_W+1:2];
                r_aw_oor  <= w_aw_oor;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
        end
    end

    // Write response: raised on commit, held until bready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_oor ? c_SLVERR : c_OKAY;
        end else if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register array with per-byte write enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !r_aw_oor) begin
            for (int k = 0; k < c_NBYTES; k++) begin
                if (r_wstrb[k]) begin
                    r_regs[r_aw_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read FSM next state and arready
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (arvalid) begin
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read data capture on AR handshake; old register value wins over a same-edge commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= c_OKAY;
        end else if (w_ar_hs) begin
            if (w_ar_oor) begin
                r_rdata <= '0;
                r_rresp <= c_SLVERR;
            end else begin
                r_rdata <= r_regs[w_ar_idx];
                r_rresp <= c_OKAY;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_regs
// Brief    : Directed self-checking bench for axi4_lite_slave_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regs;

    logic         clk;
    logic         rst;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] reg_out;

    int           n_vec;
    int           n_miss;
    logic [511:0] e_regs;
    logic [1:0]   resp;
    logic [31:0]  rd;

    axi4_lite_slave_regs #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .reg_out (reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that takes the response
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r);
        bit aw_hs;
        bit w_hs;
        int n;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bvalid) break;
            n++;
        end
        chk("wr_bvalid_seen", bvalid, 1);
        r = bresp;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        bit ar_hs;
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            @(negedge clk);
            ar_hs = arready;
            @(posedge clk); #1;
            if (ar_hs) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rvalid) break;
            n++;
        end
        chk("rd_rvalid_seen", rvalid, 1);
        d = rdata;
        r = rresp;
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; e_regs = '0;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid",  bvalid,  0);
        chk("rst_rvalid",  rvalid,  0);
        chk("rst_awready", awready, 1);
        chk("rst_wready",  wready,  1);
        chk("rst_arready", arready, 1);
        chk("rst_regs",    reg_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // AW and W together: bvalid one cycle after acceptance
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("t1_bvalid_early", bvalid, 0);
        chk("t1_awready_held", awready, 0);
        @(negedge clk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp",  bresp,  2'b00);
        chk("t1_reg1",   reg_out[63:32], 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t1_bvalid_clr", bvalid, 0);
        e_regs[63:32] = 32'hDEADBEEF;

        // W three cycles ahead of AW
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        chk("t2_wready_drop", wready, 0);
        chk("t2_no_bvalid",   bvalid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_still_wait", bvalid, 0);
        awaddr = 32'h08; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("t2_bvalid_early", bvalid, 0);
        @(negedge clk);
        chk("t2_bvalid", bvalid, 1);
        chk("t2_bresp",  bresp,  2'b00);
        chk("t2_reg2",   reg_out[95:64], 32'h11223344);
        @(posedge clk); #1;

        // Byte strobe
        do_write(32'h08, 32'hDEADBEEF, 4'hF, resp);
        chk("t3_resp_full", resp, 2'b00);
        do_write(32'h08, 32'h000000AA, 4'h1, resp);
        chk("t3_resp_byte", resp, 2'b00);
        e_regs[95:64] = 32'hDEADBEAA;
        chk("t3_regs", reg_out, e_regs);

        // Out-of-range write and read
        do_write(32'h40, 32'h12345678, 4'hF, resp);
        chk("t4_bresp", resp, 2'b10);
        chk("t4_regs",  reg_out, e_regs);
        do_read(32'h40, rd, resp);
        chk("t4_rresp", resp, 2'b10);
        chk("t4_rdata", rd, 0);
        do_write(32'h1000_0004, 32'h87654321, 4'hF, resp);
        chk("t4_hi_bresp", resp, 2'b10);
        chk("t4_hi_regs",  reg_out, e_regs);

        // wstrb 0000 is an OKAY no-op
        do_write(32'h04, 32'hFFFFFFFF, 4'h0, resp);
        chk("t5_resp", resp, 2'b00);
        chk("t5_regs", reg_out, e_regs);

        // Read with rready stalled for five cycles
        rready = 1'b0; araddr = 32'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_rvalid",  rvalid,  1);
            chk("t6_rdata",   rdata,   32'hDEADBEEF);
            chk("t6_rresp",   rresp,   2'b00);
            chk("t6_arready", arready, 0);
            @(posedge clk);
        end
        #1;
        rready = 1'b1;
        @(posedge clk); #1;
        chk("t6_arready_back", arready, 1);
        chk("t6_rvalid_clr",   rvalid,  0);

        // Low address bits ignored; unwritten register reads zero
        do_read(32'h0A, rd, resp);
        chk("t7_rdata_unal", rd, 32'hDEADBEAA);
        chk("t7_rresp_unal", resp, 2'b00);
        do_read(32'h3C, rd, resp);
        chk("t7_rdata_r15", rd, 0);

        // Read and commit to the same register on the same edge
        awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h04; arvalid = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("t8_rvalid",   rvalid, 1);
        chk("t8_bvalid",   bvalid, 1);
        chk("t8_old_data", rdata,  32'hDEADBEEF);
        @(posedge clk); #1;
        e_regs[63:32] = 32'h0BADF00D;
        do_read(32'h04, rd, resp);
        chk("t8_new_data", rd, 32'h0BADF00D);
        chk("t8_regs", reg_out, e_regs);

        // Reset with both responses pending
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h0C; awvalid = 1'b1; wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        chk("t9_bvalid_pend", bvalid, 1);
        chk("t9_rvalid_pend", rvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t9_bvalid_rst",  bvalid,  0);
        chk("t9_rvalid_rst",  rvalid,  0);
        chk("t9_regs_rst",    reg_out, 0);
        chk("t9_arready_rst", arready, 1);
        @(posedge clk); #1;
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        e_regs = '0;
        do_write(32'h0C, 32'hCAFE0001, 4'hF, resp);
        chk("t9_resp_after", resp, 2'b00);
        e_regs[127:96] = 32'hCAFE0001;
        chk("t9_regs_after", reg_out, e_regs);
        do_read(32'h0C, rd, resp);
        chk("t9_rdata_after", rd, 32'hCAFE0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
